famicom_pad_serializer: RTL and testbench
=========================================

FAMICOM_PAD_SERIALIZER -- requirements
Module: famicom_pad_serializer

Interface
REQ-001 SHALL have parameter NUM_PADS, default 1: number of emulated controllers, legal 1..4.
REQ-002 SHALL have parameter BITS, default 8: shift bits per pad, legal 8..16.
REQ-003 SHALL have parameter CHAIN, default 0: 0 = one data line per pad; 1 = all pads daisy-chained onto famicom_data[0].
REQ-004 SHALL have parameter FILL_BIT, default 1'b0: value shifted in behind the last real bit.
REQ-005 SHALL have parameter TURBO_DIV, default 4: latch pulses per turbo phase, legal 1..255.
REQ-006 SHALL have port clk_sys, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port famicom_latch, input, 1: latch from Gigatron, asynchronous to clk_sys.
REQ-009 SHALL have port famicom_pulse, input, 1: shift clock from Gigatron, asynchronous to clk_sys.
REQ-010 SHALL have port joy_in, input, NUM_PADS*BITS: active-high buttons; pad p at [p*BITS +: BITS]; bit 0 shifts out first.
REQ-011 SHALL have port kbd_ascii, input, 8: keyboard code merged into pad 0; 8'hFF = idle.
REQ-012 SHALL have port turbo_mask, input, NUM_PADS*BITS: per-button turbo enable, same layout as joy_in.
REQ-013 SHALL have port famicom_data, output, NUM_PADS: serial data, active-low (0 = pressed).
REQ-014 SHALL have port bit_count, output, $clog2(NUM_PADS*BITS+1): bits shifted since last load, saturating.

Function
REQ-015 SHALL pass famicom_latch and famicom_pulse through 2-flop synchronisers; edge detection uses a third registered copy.
REQ-016 SHALL, while synchronised latch is high, reload every cycle: word[p][i] = ~joy_in[p][i] & m[i]; m[i] = kbd_ascii[7-i] for p=0, i<8; otherwise m[i] = 1.
REQ-017 SHALL clear bit_count to 0 on every reload cycle.
REQ-018 SHALL, on a rising edge of synchronised famicom_pulse with latch low, shift every active register one place toward bit 0, inserting FILL_BIT at the top, and increment bit_count.
REQ-019 SHALL give latch priority when a latch-high cycle and a pulse edge coincide: reload, no shift.
REQ-020 SHALL, with CHAIN=1, form one NUM_PADS*BITS register (pad 0 lowest); famicom_data[0] = bit 0; famicom_data[NUM_PADS-1:1] = FILL_BIT.
REQ-021 SHALL, with CHAIN=0, drive famicom_data[p] = bit 0 of pad p register.
REQ-022 SHALL saturate bit_count at BITS (CHAIN=0) or NUM_PADS*BITS (CHAIN=1); further pulses shift FILL_BIT only, no wrap.
REQ-023 SHALL register famicom_data; reflect reload/shift one clk_sys cycle after the synchronised event (3 cycles after the input pin).

Reset
REQ-024 SHALL, while reset_n low: all shift registers = FILL_BIT-filled, famicom_data = {NUM_PADS{FILL_BIT}}, bit_count = 0, synchronisers = 0, turbo counter and phase = 0.
REQ-025 SHALL abort any partial shift on reset; first action after release requires a fresh latch.

Configuration
REQ-026 SHALL implement turbo only when FAMICOM_TURBO_EN is defined: 8-bit counter increments on each synchronised latch falling edge; at TURBO_DIV-1 wraps to 0 and toggles phase; buttons with turbo_mask=1 load as released while phase=1.
REQ-027 SHALL, without FAMICOM_TURBO_EN, ignore turbo_mask and contain no turbo counter or phase logic.

Structure
REQ-028 SHALL place in package famicom_pkg: legal parameter limits, FILL default, helper function to bit-reverse an 8-bit key code.
REQ-029 SHALL use one sub-module famicom_sync_edge (2-flop synchroniser plus rise/fall detect), instantiated twice.

Verification
REQ-030 NUM_PADS=1, BITS=8, kbd_ascii=FF, joy_in=8'h01, latch pulse, 8 pulses -> famicom_data sequence 0,1,1,1,1,1,1,1, then 0 (FILL_BIT); bit_count=8.
REQ-031 joy_in=0, kbd_ascii=8'h41, latch, 8 pulses -> sequence 0,1,0,0,0,0,0,1 (bit-reversed 'A').
REQ-032 CHAIN=1, NUM_PADS=2, pad0=0, pad1=8'h80, latch, 16 pulses -> only 16th bit 0; bit_count=16, 17th pulse stays 16.
REQ-033 Latch held high plus 3 pulses -> no shift, bit_count=0; joy_in change during latch visible 3 cycles later.
REQ-034 Reset_n asserted after 4 pulses -> famicom_data=FILL_BIT and bit_count=0 immediately (async).
REQ-035 FAMICOM_TURBO_EN, TURBO_DIV=2, turbo_mask bit0=1, joy_in bit0=1, 8 frames -> first bit 0,0,1,1,0,0,1,1 per frame.

Source files
------------

// File: rtl/famicom_pkg.sv
// Shared limits, defaults and key-code helper for the Famicom pad serializer.
package famicom_pkg;

   localparam int PADS_MIN      = 1;
   localparam int PADS_MAX      = 4;
   localparam int BITS_MIN      = 8;
   localparam int BITS_MAX      = 16;
   localparam int TURBO_DIV_MIN = 1;
   localparam int TURBO_DIV_MAX = 255;

   localparam logic FILL_DEFAULT = 1'b0;

   // Key codes are sent MSB first while pad bits go out LSB first.
   function automatic logic [7:0] bit_rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

endpackage

// File: rtl/famicom_sync_edge.sv
// Two-flop synchroniser with a third registered copy for rise/fall detection.
module famicom_sync_edge (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [2:0] sync_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[1:0], async_in};
   end

   assign level = sync_q[1];
   assign rise  = sync_q[1] & ~sync_q[2];
   assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/famicom_pad_serializer.sv
// Emulates Famicom pad shift registers for the Gigatron latch/pulse interface.
// Optional turbo buttons are compiled in with FAMICOM_TURBO_EN.
module famicom_pad_serializer
   import famicom_pkg::*;
#(
   parameter int   NUM_PADS  = 1,
   parameter int   BITS      = 8,
   parameter int   CHAIN     = 0,
   parameter logic FILL_BIT  = FILL_DEFAULT,
   parameter int   TURBO_DIV = 4
) (
   input  logic                                   clk_sys,
   input  logic                                   reset_n,
   input  logic                                   famicom_latch,
   input  logic                                   famicom_pulse,
   input  logic [NUM_PADS*BITS-1:0]               joy_in,
   input  logic [7:0]                             kbd_ascii,
   input  logic [NUM_PADS*BITS-1:0]               turbo_mask,
   output logic [NUM_PADS-1:0]                    famicom_data,
   output logic [$clog2(NUM_PADS*BITS+1)-1:0]     bit_count
);

   localparam int TOTAL = NUM_PADS * BITS;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] SAT = (CHAIN != 0) ? CW'(TOTAL) : CW'(BITS);

   if (NUM_PADS < PADS_MIN || NUM_PADS > PADS_MAX) begin : g_bad_pads
      $error("famicom_pad_serializer: NUM_PADS out of range");
   end
   if (BITS < BITS_MIN || BITS > BITS_MAX) begin : g_bad_bits
      $error("famicom_pad_serializer: BITS out of range");
   end
   if (TURBO_DIV < TURBO_DIV_MIN || TURBO_DIV > TURBO_DIV_MAX) begin : g_bad_div
      $error("famicom_pad_serializer: TURBO_DIV out of range");
   end

   logic latch_lvl, latch_rise, latch_fall;
   logic pulse_lvl, pulse_rise, pulse_fall;

   famicom_sync_edge u_sync_latch (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .async_in (famicom_latch),
      .level    (latch_lvl),
      .rise     (latch_rise),
      .fall     (latch_fall)
   );

   famicom_sync_edge u_sync_pulse (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .async_in (famicom_pulse),
      .level    (pulse_lvl),
      .rise     (pulse_rise),
      .fall     (pulse_fall)
   );

   logic turbo_phase;

`ifdef FAMICOM_TURBO_EN
   logic [7:0] turbo_cnt;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         turbo_cnt   <= '0;
         turbo_phase <= 1'b0;
      end else if (latch_fall) begin
         if (turbo_cnt == 8'(TURBO_DIV - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
         end else begin
            turbo_cnt <= turbo_cnt + 8'd1;
         end
      end
   end

   logic unused_edges;
   assign unused_edges = ^{latch_rise, pulse_lvl, pulse_fall};
`else
   assign turbo_phase = 1'b0;

   logic unused_edges;
   assign unused_edges = ^{latch_rise, latch_fall, pulse_lvl, pulse_fall, turbo_mask, turbo_phase};
`endif

   logic [TOTAL-1:0] sreg, load_word, shift_word;
   logic [BITS-1:0]  pad0_mask;
   logic             armed;

   always_comb begin
      pad0_mask      = '1;
      pad0_mask[7:0] = bit_rev8(kbd_ascii);
      load_word      = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         for (int i = 0; i < BITS; i++) begin
            logic pressed;
            pressed = joy_in[p*BITS + i];
`ifdef FAMICOM_TURBO_EN
            if (turbo_phase && turbo_mask[p*BITS + i]) pressed = 1'b0;
`endif
            load_word[p*BITS + i] = ~pressed & ((p == 0) ? pad0_mask[i] : 1'b1);
         end
      end
   end

   always_comb begin
      shift_word = {TOTAL{FILL_BIT}};
      if (CHAIN != 0) begin
         shift_word = {FILL_BIT, sreg[TOTAL-1:1]};
      end else begin
         for (int p = 0; p < NUM_PADS; p++)
            shift_word[p*BITS +: BITS] = {FILL_BIT, sreg[p*BITS + 1 +: BITS - 1]};
      end
   end

   // armed is cleared by reset so stray pulses cannot shift until a fresh latch.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sreg      <= {TOTAL{FILL_BIT}};
         bit_count <= '0;
         armed     <= 1'b0;
      end else if (latch_lvl) begin
         sreg      <= load_word;
         bit_count <= '0;
         armed     <= 1'b1;
      end else if (pulse_rise && armed) begin
         sreg <= shift_word;
         if (bit_count != SAT) bit_count <= bit_count + CW'(1);
      end
   end

   always_comb begin
      famicom_data = {NUM_PADS{FILL_BIT}};
      if (CHAIN != 0) begin
         famicom_data[0] = sreg[0];
      end else begin
         for (int p = 0; p < NUM_PADS; p++) famicom_data[p] = sreg[p*BITS];
      end
   end

endmodule

// File: tb/tb_famicom_pad_serializer.sv
// Directed bench: one pad per line (TURBO_DIV=2) and a two-pad daisy chain.
module tb_famicom_pad_serializer;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        latch   = 1'b0;
   logic        pulse   = 1'b0;
   logic [7:0]  kbd     = 8'hFF;

   logic [7:0]  joy_a   = 8'h00;
   logic [7:0]  tmask_a = 8'h00;
   logic [0:0]  data_a;
   logic [3:0]  bc_a;

   logic [15:0] joy_c   = 16'h0000;
   logic [15:0] tmask_c = 16'h0000;
   logic [1:0]  data_c;
   logic [4:0]  bc_c;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_sys = ~clk_sys;

   famicom_pad_serializer #(.NUM_PADS(1), .BITS(8), .CHAIN(0), .FILL_BIT(1'b0), .TURBO_DIV(2)) dut_a (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .famicom_latch (latch),
      .famicom_pulse (pulse),
      .joy_in        (joy_a),
      .kbd_ascii     (kbd),
      .turbo_mask    (tmask_a),
      .famicom_data  (data_a),
      .bit_count     (bc_a)
   );

   famicom_pad_serializer #(.NUM_PADS(2), .BITS(8), .CHAIN(1), .FILL_BIT(1'b0), .TURBO_DIV(4)) dut_c (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .famicom_latch (latch),
      .famicom_pulse (pulse),
      .joy_in        (joy_c),
      .kbd_ascii     (kbd),
      .turbo_mask    (tmask_c),
      .famicom_data  (data_c),
      .bit_count     (bc_c)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic do_latch();
      latch = 1'b1; cyc(4);
      latch = 1'b0; cyc(4);
   endtask

   task automatic do_pulse();
      pulse = 1'b1; cyc(4);
      pulse = 1'b0; cyc(4);
   endtask

   logic [7:0]  seq_a;
   logic [15:0] seq_c;
   logic [7:0]  turbo_exp;

   initial begin
      cyc(3);
      chk("reset data_a", data_a, 1'b0);
      chk("reset bc_a", bc_a, 4'd0);
      chk("reset data_c", data_c, 2'b00);
      chk("reset bc_c", bc_c, 5'd0);
      reset_n = 1'b1;
      cyc(2);

      // latch latency: nothing pressed loads all ones, visible on the third edge
      joy_a = 8'h00; kbd = 8'hFF;
      latch = 1'b1;
      cyc(2); chk("latch lat 2 cyc", data_a, 1'b0);
      cyc(1); chk("latch lat 3 cyc", data_a, 1'b1);
      cyc(1); latch = 1'b0; cyc(4);

      // joy bit0 pressed; pulse latency then full sequence
      joy_a = 8'h01;
      seq_a = 8'b1111_1110;
      do_latch();
      chk("joy01 bit0", data_a, seq_a[0]);
      chk("joy01 bc0", bc_a, 4'd0);
      pulse = 1'b1;
      cyc(2); chk("pulse lat 2 cyc", data_a, seq_a[0]);
      cyc(1); chk("pulse lat 3 cyc", data_a, seq_a[1]);
      cyc(1); pulse = 1'b0; cyc(4);
      chk("joy01 bc1", bc_a, 4'd1);
      for (int k = 2; k < 8; k++) begin
         do_pulse();
         chk($sformatf("joy01 bit%0d", k), data_a, seq_a[k]);
         chk($sformatf("joy01 bc%0d", k), bc_a, 4'(k));
      end
      do_pulse();
      chk("joy01 fill", data_a, 1'b0);
      chk("joy01 bc8", bc_a, 4'd8);

      // keyboard 'A' goes out bit-reversed
      joy_a = 8'h00; kbd = 8'h41;
      seq_a = 8'h82;
      do_latch();
      chk("kbdA bit0", data_a, seq_a[0]);
      for (int k = 1; k < 8; k++) begin
         do_pulse();
         chk($sformatf("kbdA bit%0d", k), data_a, seq_a[k]);
      end
      do_pulse();
      chk("kbdA fill", data_a, 1'b0);
      chk("kbdA bc8", bc_a, 4'd8);
      do_pulse();
      chk("kbdA bc sat", bc_a, 4'd8);

      // daisy chain: only pad1 bit7 pressed -> 16th bit low
      kbd = 8'hFF; joy_c = 16'h8000;
      seq_c = 16'h7FFF;
      do_latch();
      chk("chain bit0", data_c[0], seq_c[0]);
      chk("chain line1", data_c[1], 1'b0);
      for (int k = 1; k < 16; k++) begin
         do_pulse();
         chk($sformatf("chain bit%0d", k), data_c[0], seq_c[k]);
      end
      do_pulse();
      chk("chain fill", data_c[0], 1'b0);
      chk("chain bc16", bc_c, 5'd16);
      do_pulse();
      chk("chain bc sat", bc_c, 5'd16);
      chk("chain fill sat", data_c[0], 1'b0);

      // latch held high: pulses ignored, joy change reloads
      joy_a = 8'h01;
      latch = 1'b1; cyc(4);
      chk("hold load", data_a, 1'b0);
      for (int k = 0; k < 3; k++) do_pulse();
      chk("hold bc", bc_a, 4'd0);
      chk("hold data", data_a, 1'b0);
      joy_a = 8'h00;
      cyc(3);
      chk("hold joy change", data_a, 1'b1);
      latch = 1'b0; cyc(4);

      // async reset mid-shift
      do_latch();
      for (int k = 0; k < 4; k++) do_pulse();
      chk("pre-reset bc", bc_a, 4'd4);
      chk("pre-reset data", data_a, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("async rst data_a", data_a, 1'b0);
      chk("async rst bc_a", bc_a, 4'd0);
      chk("async rst bc_c", bc_c, 5'd0);
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      do_pulse();
      chk("post-reset no shift bc", bc_a, 4'd0);
      chk("post-reset no shift data", data_a, 1'b0);

      // turbo on bit0: pressed/released pattern alternates every TURBO_DIV frames
`ifdef FAMICOM_TURBO_EN
      turbo_exp = 8'b1100_1100;
`else
      turbo_exp = 8'b0000_0000;
`endif
      joy_a = 8'h01; tmask_a = 8'h01;
      for (int f = 0; f < 8; f++) begin
         do_latch();
         chk($sformatf("turbo frame%0d", f), data_a, turbo_exp[f]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
